// File: rtl/exception_vector_controller.sv
// Exception vector controller: captures per-source exception request pulses
// into sticky pending bits. It picks the highest-priority eligible source,
// offers its vector address to the fetch stage until the redirect is taken,
// and then waits a programmable number of holdoff cycles before it offers
// another exception.
module exception_vector_controller #(
   parameter int          NUM_SRC    = 7,
   parameter int          HOLDOFF    = 2,
   parameter logic [31:0] HIVEC_BASE = 32'hFFFF0000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] ExceptionReqW,
   input  logic [NUM_SRC-1:0] ExceptionMaskW,
   input  logic               HighVectorsW,
   input  logic               RedirectTakenW,
   output logic [31:0]        VectorPCnextF,
   output logic               ExceptionVectorSelectW,
   output logic [2:0]         ExceptionIdW,
   output logic [NUM_SRC-1:0] PendingW
);

   typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

   // Last count value of the holdoff window. The value is unused when
   // HOLDOFF is 0, because HOLD is never entered in that case.
   localparam logic [3:0] HOLD_LAST = 4'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

   state_t               state, state_n;
   logic [3:0]           cnt, cnt_n;
   logic [31:0]          pc_n;
   logic                 sel_n;
   logic [2:0]           id_n;
   logic [NUM_SRC-1:0]   pend_n;

   // The 7-bit views let the priority and clear logic always work on the
   // full source set. Sources at or above NUM_SRC are tied to zero.
   logic [6:0]           pend7, elig7, clr7;
   logic [2:0]           win;
   logic                 any_elig;
   logic [31:0]          base;

   // Offsets follow the classic vector table: the 0x14 slot is reserved.
   function automatic logic [31:0] vec_off(input logic [2:0] i);
      logic [2:0] slot;
      slot = (i <= 3'd4) ? i : 3'(i + 3'd1);
      return {27'b0, slot, 2'b00};
   endfunction

   // Widen the pending bits and apply the mask. Reset (bit 0) cannot be masked.
   always_comb begin
      pend7 = '0;
      elig7 = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pend7[i] = PendingW[i];
         elig7[i] = PendingW[i] & ((i == 0) | ~ExceptionMaskW[i]);
      end
   end

   // Fixed-priority winner: Reset > DAbort > FIQ > IRQ > PAbort > Undef > SWI.
   always_comb begin
      win      = 3'd0;
      any_elig = |elig7;
      if      (elig7[0]) win = 3'd0;
      else if (elig7[4]) win = 3'd4;
      else if (elig7[6]) win = 3'd6;
      else if (elig7[5]) win = 3'd5;
      else if (elig7[3]) win = 3'd3;
      else if (elig7[1]) win = 3'd1;
      else if (elig7[2]) win = 3'd2;
   end

   assign base = HighVectorsW ? HIVEC_BASE : 32'h0;

   // Next-state logic, next outputs, and the pending clear mask for the offer FSM.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pc_n    = VectorPCnextF;
      id_n    = ExceptionIdW;
      sel_n   = ExceptionVectorSelectW;
      clr7    = '0;
      case (state)
         IDLE: begin
            sel_n = 1'b0;
            if (any_elig) begin
               pc_n    = base | vec_off(win);
               id_n    = win;
               sel_n   = 1'b1;
               state_n = OFFER;
            end
         end
         OFFER: begin
            sel_n = 1'b1;
            if (RedirectTakenW) begin
               // Taking Reset discards every other outstanding exception.
               if (ExceptionIdW == 3'd0) clr7 = '1;
               else                      clr7[ExceptionIdW] = 1'b1;
               sel_n = 1'b0;
               cnt_n = '0;
               state_n = (HOLDOFF == 0) ? IDLE : HOLD;
            end else if (pend7[0] && ExceptionIdW != 3'd0) begin
               // Only Reset preempts an offer. The displaced source stays pending.
               pc_n = base;
               id_n = 3'd0;
            end
         end
         HOLD: begin
            sel_n = 1'b0;
            if (cnt == HOLD_LAST) state_n = IDLE;
            else                  cnt_n   = cnt + 4'd1;
         end
         default: begin
            sel_n   = 1'b0;
            state_n = IDLE;
         end
      endcase
      // A new request beats a same-cycle clear, so nothing is lost.
      pend_n = (PendingW & ~clr7[NUM_SRC-1:0]) | ExceptionReqW;
   end

   // State, holdoff counter, pending bits and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state                  <= IDLE;
         cnt                    <= '0;
         PendingW               <= '0;
         VectorPCnextF          <= 32'h0;
         ExceptionVectorSelectW <= 1'b0;
         ExceptionIdW           <= 3'd0;
      end else begin
         state                  <= state_n;
         cnt                    <= cnt_n;
         PendingW               <= pend_n;
         VectorPCnextF          <= pc_n;
         ExceptionVectorSelectW <= sel_n;
         ExceptionIdW           <= id_n;
      end
   end

endmodule

// File: tb/tb_exception_vector_controller.sv
// Directed bench for exception_vector_controller. A behavioural model
// predicts the outputs and is checked on every falling edge. Hand-computed
// literal checks pin the model to the expected scenarios.
module tb_exception_vector_controller;

   localparam int          NUM_SRC    = 7;
   localparam int          HOLDOFF    = 2;
   localparam logic [31:0] HIVEC_BASE = 32'hFFFF0000;

   logic               clk = 1'b0;
   logic               reset;
   logic [NUM_SRC-1:0] req, mask;
   logic               hv, taken;
   logic [31:0]        pc;
   logic               sel;
   logic [2:0]         id;
   logic [NUM_SRC-1:0] pend;

   int total = 0;
   int bad   = 0;

   exception_vector_controller #(
      .NUM_SRC(NUM_SRC), .HOLDOFF(HOLDOFF), .HIVEC_BASE(HIVEC_BASE)
   ) dut (
      .clk(clk), .reset(reset),
      .ExceptionReqW(req), .ExceptionMaskW(mask),
      .HighVectorsW(hv), .RedirectTakenW(taken),
      .VectorPCnextF(pc), .ExceptionVectorSelectW(sel),
      .ExceptionIdW(id), .PendingW(pend)
   );

   always #5 clk = ~clk;

   // Behavioural model. There is either an offer in progress or not. After a
   // take, "quiet" counts down HOLDOFF+1 silent cycles. Requests always
   // accumulate into the pending set.
   bit [NUM_SRC-1:0] m_pend;
   bit               m_sel;
   int               m_id;
   logic [31:0]      m_pc;
   int               m_quiet;
   int               order [7] = '{0, 4, 6, 5, 3, 1, 2};

   function automatic logic [31:0] addr_of(input int i, input logic h);
      int off;
      off = (i <= 4) ? 4 * i : 4 * (i + 1);
      return (h ? HIVEC_BASE : 32'h0) | off;
   endfunction

   always @(posedge clk) begin
      bit [NUM_SRC-1:0] clr;
      int w;
      if (reset) begin
         m_pend = '0; m_sel = 0; m_id = 0; m_pc = 32'h0; m_quiet = 0;
      end else begin
         clr = '0;
         if (m_sel) begin
            if (taken) begin
               if (m_id == 0) clr = '1;
               else           clr[m_id] = 1'b1;
               m_sel = 0;
               m_quiet = HOLDOFF;
            end else if (m_pend[0] && m_id != 0) begin
               m_id = 0;
               m_pc = addr_of(0, hv);
            end
         end else if (m_quiet > 0) begin
            m_quiet--;
         end else begin
            w = -1;
            for (int k = 6; k >= 0; k--)
               if (order[k] < NUM_SRC && m_pend[order[k]] &&
                   (order[k] == 0 || !mask[order[k]])) w = order[k];
            if (w >= 0) begin
               m_sel = 1; m_id = w; m_pc = addr_of(w, hv);
            end
         end
         m_pend = (m_pend & ~clr) | req;
      end
   end

   // Compare the DUT outputs against the model on every falling edge.
   always @(negedge clk) begin
      total++;
      if (pend !== m_pend || sel !== m_sel || pc !== m_pc || id !== 3'(m_id)) begin
         bad++;
         $display("FAIL model t=%0t: got pend=%b sel=%b pc=%h id=%0d, want pend=%b sel=%b pc=%h id=%0d",
                  $time, pend, sel, pc, id, m_pend, m_sel, m_pc, m_id);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      #1;
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   initial begin
      reset = 1; req = '0; mask = '0; hv = 0; taken = 0;
      tick(2);
      reset = 0;
      chk("rst_pend", 32'(pend), 32'h0);
      chk("rst_sel",  32'(sel),  32'h0);
      chk("rst_pc",   pc,        32'h0);
      chk("rst_id",   32'(id),   32'h0);

      // Single SWI request, low vectors.
      req = 7'b0000100; tick(); req = '0;
      chk("single_pend", 32'(pend), 32'h4);
      chk("single_nosel", 32'(sel), 32'h0);
      tick();
      chk("single_sel", 32'(sel), 32'h1);
      chk("single_pc",  pc,       32'h8);
      chk("single_id",  32'(id),  32'h2);
      taken = 1; tick(2);  // Taken is ignored in HOLD.
      taken = 0;
      chk("single_cleared", 32'(pend), 32'h0);
      tick(4);

      // IRQ and Data Abort together, high vectors.
      hv = 1; req = 7'b0110000; tick(); req = '0; tick();
      chk("prio_pc", pc,      32'hFFFF0010);
      chk("prio_id", 32'(id), 32'h4);
      taken = 1; tick(); taken = 0;
      chk("prio_hold0", 32'(sel), 32'h0);
      tick(2);
      chk("prio_hold2", 32'(sel), 32'h0);
      tick();
      chk("prio_irq_pc", pc,      32'hFFFF0018);
      chk("prio_irq_id", 32'(id), 32'h5);
      taken = 1; tick(); taken = 0; tick(4);

      // Masked FIQ, then unmask.
      hv = 0; mask = 7'b1000000; req = 7'b1000000; tick(); req = '0; tick(3);
      chk("mask_blocked", 32'(sel),  32'h0);
      chk("mask_pend",    32'(pend), 32'h40);
      mask = '0; tick(2);
      chk("mask_pc", pc,      32'h1C);
      chk("mask_id", 32'(id), 32'h6);
      mask = 7'b1000000; tick();  // Re-masking does not withdraw the offer.
      chk("mask_keep", 32'(sel), 32'h1);
      taken = 1; tick(); taken = 0; mask = '0; tick(4);

      // Reset preempts an Undef offer.
      req = 7'b0000010; tick(); req = '0; tick();
      chk("pre_undef_pc", pc, 32'h4);
      req = 7'b0000001; tick(); req = '0;
      chk("pre_still_undef", 32'(id), 32'h1);
      tick();
      chk("pre_pc", pc,      32'h0);
      chk("pre_id", 32'(id), 32'h0);
      chk("pre_undef_pend", 32'(pend), 32'h3);
      taken = 1; tick(); taken = 0;
      chk("pre_allclr", 32'(pend), 32'h0);
      tick(4);

      // Set/clear collision on SWI.
      req = 7'b0000100; tick(); req = '0; tick();
      taken = 1; req = 7'b0000100; tick(); taken = 0; req = '0;
      chk("coll_pend", 32'(pend), 32'h4);
      tick(3);
      chk("coll_reoffer_sel", 32'(sel), 32'h1);
      chk("coll_reoffer_pc",  pc,       32'h8);
      taken = 1; tick(); taken = 0; tick(4);

      // Reset during an offer.
      req = 7'b0001000; tick(); req = '0; tick();
      chk("rmid_pc", pc, 32'hC);
      reset = 1; req = 7'b0000010; tick(); reset = 0; req = '0;
      chk("rmid_pend", 32'(pend), 32'h0);
      chk("rmid_sel",  32'(sel),  32'h0);
      chk("rmid_pc0",  pc,        32'h0);
      taken = 1; tick(4); taken = 0;  // Taken is ignored while idle.
      chk("rmid_quiet", 32'(sel), 32'h0);
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exception_vector_controller.md
EXCEPTION_VECTOR_CONTROLLER -- requirements
Module: exception_vector_controller

Interface
REQ-001 SHALL have parameter NUM_SRC, default 7, meaning the number of exception sources (legal 1..7); bit 0 = Reset, 1 = Undef, 2 = SWI, 3 = Prefetch Abort, 4 = Data Abort, 5 = IRQ, 6 = FIQ.
REQ-002 SHALL have parameter HOLDOFF, default 2, meaning the number of cycles after a taken redirect during which no new exception is issued (legal 0..15).
REQ-003 SHALL have parameter HIVEC_BASE, default 32'hFFFF0000, meaning the vector base used when high vectors are enabled.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port ExceptionReqW, input, NUM_SRC, one-cycle request pulses per source.
REQ-007 SHALL have port ExceptionMaskW, input, NUM_SRC, per-source issue mask (1 = blocked); bit 0 is ignored.
REQ-008 SHALL have port HighVectorsW, input, 1, selecting HIVEC_BASE (1) or 32'h0 (0).
REQ-009 SHALL have port RedirectTakenW, input, 1, pipeline acceptance of the current redirect.
REQ-010 SHALL have port VectorPCnextF, output, 32, the registered vector address.
REQ-011 SHALL have port ExceptionVectorSelectW, output, 1, high while a redirect is offered.
REQ-012 SHALL have port ExceptionIdW, output, 3, the index of the offered source.
REQ-013 SHALL have port PendingW, output, NUM_SRC, the current pending bits.

Function
REQ-014 SHALL hold one sticky pending bit per source, set in the cycle after ExceptionReqW[i] is high.
REQ-015 SHALL treat a source as eligible when it is pending and, for i>0, ExceptionMaskW[i]=0.
REQ-016 SHALL select the winner by fixed priority: Reset > Data Abort > FIQ > IRQ > Prefetch Abort > Undef > SWI, restricted to indices < NUM_SRC.
REQ-017 SHALL compute the vector offset as 4*i for i<=4 and 4*(i+1) for i>=5 (0x00, 0x04, 0x08, 0x0C, 0x10, 0x18, 0x1C); the 0x14 slot is never produced.
REQ-018 SHALL form VectorPCnextF as base OR offset, with the base taken from HighVectorsW sampled in the cycle the winner is latched.
REQ-019 SHALL implement the states IDLE, OFFER and HOLD.
REQ-020 IDLE: on any eligible source, SHALL latch the winner, ID and address and enter OFFER; outputs are valid in the next cycle (1-cycle latency).
REQ-021 OFFER: SHALL keep ExceptionVectorSelectW=1 with stable VectorPCnextF and ExceptionIdW until RedirectTakenW=1.
REQ-022 OFFER with RedirectTakenW=1: SHALL clear the offered pending bit, deassert select next cycle, and enter HOLD (or IDLE if HOLDOFF=0).
REQ-023 HOLD: SHALL count HOLDOFF cycles with select=0, then return to IDLE; requests SHALL still be captured during HOLD.
REQ-024 OFFER: a newly pending Reset SHALL preempt any non-Reset offer next cycle (address and ID updated, previous bit stays pending); no other source preempts.
REQ-025 A pending Reset, when taken, SHALL clear all pending bits.
REQ-026 When a request and the clear of the same bit coincide, set SHALL win and the bit stays pending.
REQ-027 Mask changes during OFFER SHALL NOT withdraw the current offer.
REQ-028 RedirectTakenW outside OFFER SHALL be ignored.

Reset
REQ-029 reset=1 SHALL force IDLE, PendingW=0, VectorPCnextF=32'h0, ExceptionVectorSelectW=0, ExceptionIdW=0, and clear the HOLD counter, overriding any in-flight offer or request that cycle.

Verification
REQ-030 Single request: ExceptionReqW=7'b0000100, HighVectorsW=0 -> next cycle PendingW[2]=1; following cycle select=1, VectorPCnextF=32'h8, ExceptionIdW=2; hold until taken.
REQ-031 Priority and high vectors: IRQ and Data Abort together, HighVectorsW=1 -> offer 32'hFFFF0010 (ID 4); after take and 2 HOLD cycles, offer 32'hFFFF0018 (ID 5).
REQ-032 Masking: FIQ pending with ExceptionMaskW[6]=1 -> select stays 0; unmask -> offer 32'h1C two cycles later.
REQ-033 Preemption: Undef offered, RedirectTakenW=0, Reset pulse arrives -> offer switches to 32'h0, ID 0; after take, PendingW=0.
REQ-034 Set/clear collision: SWI offered and taken in the same cycle a new SWI pulse arrives -> PendingW[2] stays 1 and SWI is re-offered after HOLD.
REQ-035 Reset mid-offer: reset asserted during OFFER -> next cycle all outputs are at reset values and no redirect follows without a new request.
